// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC, one-outstanding imem request, output/hold slots, taken-branch redirect.
// Define FETCH_DELAY_SLOT_EN to keep the output slot (delay slot) alive across a redirect.
module fetch_pc_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000
) (
   input  logic        clk_pi,
   input  logic        reset_pi,
   input  logic        branch_valid_pi,
   input  logic        is_branch_taken_pi,
   input  logic [15:0] branch_target_pi,
   output logic        imem_req_po,
   output logic [15:0] imem_addr_po,
   input  logic        imem_rvalid_pi,
   input  logic [15:0] imem_rdata_pi,
   input  logic        stall_pi,
   output logic        instr_valid_po,
   output logic [15:0] instr_po,
   output logic [15:0] instr_pc_po
);

   localparam logic [0:0] ST_FETCH = 1'b0;
   localparam logic [0:0] ST_HOLD  = 1'b1;

   logic [0:0]  state_q, state_d;
   logic [15:0] pc_q, pc_d;
   logic [15:0] addr_q, addr_d;
   logic        req_q, req_d;
   logic        squash_q, squash_d;
   logic        out_valid_q, out_valid_d;
   logic [15:0] out_instr_q, out_instr_d;
   logic [15:0] out_pc_q, out_pc_d;
   logic        hold_valid_q, hold_valid_d;
   logic [15:0] hold_instr_q, hold_instr_d;
   logic [15:0] hold_pc_q, hold_pc_d;

   logic transfer;
   logic redirect;
   logic rsp;

   assign transfer = out_valid_q && !stall_pi;
   assign redirect = branch_valid_pi && is_branch_taken_pi;
   // req_q is low in the first cycle out of reset, so a response is only honoured for a live request
   assign rsp      = req_q && imem_rvalid_pi;

   always_comb begin
      state_d      = state_q;
      pc_d         = pc_q;
      squash_d     = squash_q;
      out_valid_d  = out_valid_q;
      out_instr_d  = out_instr_q;
      out_pc_d     = out_pc_q;
      hold_valid_d = hold_valid_q;
      hold_instr_d = hold_instr_q;
      hold_pc_d    = hold_pc_q;

      if (transfer) begin
         out_valid_d = 1'b0;
      end

      if (state_q == ST_FETCH) begin
         if (rsp) begin
            if (squash_q) begin
               squash_d = 1'b0;
            end else if (!out_valid_q || transfer) begin
               out_valid_d = 1'b1;
               out_instr_d = imem_rdata_pi;
               out_pc_d    = pc_q;
               pc_d        = pc_q + 16'd1;
            end else begin
               hold_valid_d = 1'b1;
               hold_instr_d = imem_rdata_pi;
               hold_pc_d    = pc_q;
               pc_d         = pc_q + 16'd1;
               state_d      = ST_HOLD;
            end
         end
      end else if (transfer) begin
         out_valid_d  = 1'b1;
         out_instr_d  = hold_instr_q;
         out_pc_d     = hold_pc_q;
         hold_valid_d = 1'b0;
         state_d      = ST_FETCH;
      end

      // A taken branch overrides everything; an unanswered request must have its response dropped later
      if (redirect) begin
         pc_d         = branch_target_pi;
         hold_valid_d = 1'b0;
         state_d      = ST_FETCH;
         squash_d     = (state_q == ST_FETCH) && req_q && !imem_rvalid_pi;
`ifdef FETCH_DELAY_SLOT_EN
         out_valid_d  = out_valid_q && !transfer;
         out_instr_d  = out_instr_q;
         out_pc_d     = out_pc_q;
`else
         out_valid_d  = 1'b0;
`endif
      end

      req_d  = (state_d == ST_FETCH);
      addr_d = squash_d ? addr_q : pc_d;
   end

   always_ff @(posedge clk_pi or posedge reset_pi) begin
      if (reset_pi) begin
         state_q      <= ST_FETCH;
         pc_q         <= RESET_PC;
         addr_q       <= RESET_PC;
         req_q        <= 1'b0;
         squash_q     <= 1'b0;
         out_valid_q  <= 1'b0;
         out_instr_q  <= 16'h0000;
         out_pc_q     <= 16'h0000;
         hold_valid_q <= 1'b0;
         hold_instr_q <= 16'h0000;
         hold_pc_q    <= 16'h0000;
      end else begin
         state_q      <= state_d;
         pc_q         <= pc_d;
         addr_q       <= addr_d;
         req_q        <= req_d;
         squash_q     <= squash_d;
         out_valid_q  <= out_valid_d;
         out_instr_q  <= out_instr_d;
         out_pc_q     <= out_pc_d;
         hold_valid_q <= hold_valid_d;
         hold_instr_q <= hold_instr_d;
         hold_pc_q    <= hold_pc_d;
      end
   end

   assign imem_req_po    = req_q;
   assign imem_addr_po   = addr_q;
   assign instr_valid_po = out_valid_q;
   assign instr_po       = out_instr_q;
   assign instr_pc_po    = out_pc_q;

endmodule

// File: doc/fetch_pc_unit.md
# fetch_pc_unit

Instruction-fetch stage feeding decode and, through decode, the branch comparator. Holds the 16-bit program counter, fetches one instruction at a time from instruction memory over a request/response handshake, and presents fetched instructions downstream with a valid/stall handshake. Consumes the comparator's taken result plus a target, redirects the PC, and squashes wrong-path instructions, including any response still in flight.

## Interface
- RESET_PC, 16'h0000, PC value loaded on reset (word address)
- clk_pi  in  1  clock, all state on rising edge
- reset_pi  in  1  asynchronous, active-high reset
- branch_valid_pi  in  1  a branch is resolved this cycle
- is_branch_taken_pi  in  1  comparator result, qualified by branch_valid_pi
- branch_target_pi  in  16  redirect word address
- imem_req_po  out  1  fetch request; held with address until response
- imem_addr_po  out  16  fetch word address
- imem_rvalid_pi  in  1  response valid for current request
- imem_rdata_pi  in  16  instruction word
- stall_pi  in  1  downstream cannot accept this cycle
- instr_valid_po  out  1  instr_po/instr_pc_po hold a valid instruction
- instr_po  out  16  instruction to decode
- instr_pc_po  out  16  word address of instr_po

## Operation
- Registers: pc (next fetch address), output slot (valid, instr, pc), hold slot (valid, instr, pc), squash flag, 2-state FSM.
- Transfer downstream: instr_valid_po && !stall_pi in the same cycle.
- FETCH: imem_req_po=1, imem_addr_po=pc. On imem_rvalid_pi:
  - squash set: drop data, clear squash, stay FETCH.
  - output slot empty or transferring this cycle: load output slot {rdata, pc}, pc<=pc+1.
  - output slot full and stalled: load hold slot, pc<=pc+1, go HOLD.
- HOLD: imem_req_po=0. When output transfers: output<=hold, hold invalid, go FETCH.
- Redirect (branch_valid_pi && is_branch_taken_pi) has priority over every event above:
  - pc<=branch_target_pi; output slot and hold slot invalidated; FSM->FETCH.
  - FETCH with request outstanding and no imem_rvalid_pi this cycle: set squash; request and address stay stable until the old response arrives and is dropped, then target is requested.
  - imem_rvalid_pi in same cycle: data dropped, squash not set, target requested next cycle.
  - HOLD: no request outstanding, squash not set.
- branch_valid_pi with is_branch_taken_pi=0: no effect.
- pc arithmetic is 16-bit modulo: 16'hFFFF+1 = 16'h0000, no flag.

## Timing
- Reset values: pc=RESET_PC, FSM=FETCH, squash=0, imem_req_po=0, imem_addr_po=RESET_PC, instr_valid_po=0, instr_po=0, instr_pc_po=0, hold invalid.
- imem_req_po asserted from the first rising edge after reset_pi deasserts.
- Memory may assert imem_rvalid_pi no earlier than the cycle after an address is first presented; with 1-cycle memory, sustained throughput is 1 instruction/cycle.
- Fetch-to-output latency: data captured at the imem_rvalid_pi edge, visible on instr_po the same edge.
- Redirect: instr_valid_po=0 the cycle after the redirect; target address on imem_addr_po that cycle unless squash is pending.
- Reset mid-fetch: all state reverts immediately; the outstanding request is abandoned and instruction memory must tolerate it.

## Configuration
- FETCH_DELAY_SLOT_EN defined: on redirect, the output slot is not invalidated (it is the delay slot and transfers normally); hold slot and in-flight response are still squashed.
- Undefined: output slot flushed on redirect as above.

## Test plan
- Reset, RESET_PC=16'h0040, 1-cycle memory, stall_pi=0 -> instr_pc_po = 0040, 0041, 0042 on consecutive cycles, one instruction per cycle.
- stall_pi=1 for 3 cycles with two responses returned -> output holds 0040, hold captures 0041, imem_req_po=0; release -> 0041 then 0042 in order, none lost or duplicated.
- Taken branch to 16'h0100 while request for 0043 is outstanding (rvalid 2 cycles later) -> 0043 data dropped; next instr_pc_po=0100. Without the macro, the output slot is invalid the cycle after the branch.
- Taken branch coincident with imem_rvalid_pi -> response dropped, imem_addr_po=0100 next cycle; branch_valid_pi with taken=0 -> stream unchanged.
- RESET_PC=16'hFFFF -> instr_pc_po FFFF then 0000.
- FETCH_DELAY_SLOT_EN defined, branch while output holds 0041 -> 0041 transfers, then 0100; reset_pi pulsed mid-request -> all outputs return to reset values asynchronously.
